mgt_01_fp_round_unit: RTL

- Two-stage pipelined IEEE-754 single-precision rounding stage.
- Consumes the unrounded result and exception flags produced by the FP arithmetic units (divider, multiplier, adder).
- Applies the RISC-V rounding mode and produces the final float and the RISC-V fflags vector for writeback.
- Valid/ready handshake on both sides, full throughput, backpressure supported.

---
 rtl/mgt_01_fp_round_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mgt_01_fp_round_unit.sv
// Two-stage IEEE-754 single-precision rounding stage with RISC-V rounding modes
// and fflags generation; valid/ready on both sides with full throughput.
package mgt_01_fp_round_pkg;
  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
  typedef enum logic [1:0] {CLS_NORMAL, CLS_PASS, CLS_OVF, CLS_INV} cls_e;

  typedef struct packed {
    logic [31:0] op;
    logic [2:0]  rm;       // effective mode; illegal encodings already folded to RNE
    logic        inexact;
    logic        inc;
    logic        uf;
    logic        dz;
    logic        illegal;
    cls_e        cls;
  } s1_t;
endpackage

module mgt_01_fp_round_unit
  import mgt_01_fp_round_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic [31:0] to_round_i,
  input  logic [2:0]  grs_i,
  input  logic [2:0]  round_mode_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
  input  logic        invalid_op_i,
  input  logic        zero_divide_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o,
  output logic        illegal_rm_o,
  output logic        valid_o,
  input  logic        ready_i,
  output fu_state_e   fu_state_o
);

  localparam logic [30:0] MAX_MAG = 31'h7F7FFFFF;
  localparam logic [30:0] INF_MAG = 31'h7F800000;

  logic s1_v, s2_v;
  logic adv1, adv2;
  s1_t  s1_d, s1_q;

  assign adv2       = ~s2_v | ready_i;
  assign adv1       = ~s1_v | adv2;
  assign ready_o    = adv1;
  assign valid_o    = s2_v;
  assign fu_state_o = (s1_v | s2_v) ? BUSY : FREE;

  // Stage 1: increment decision and special-case classification
  always_comb begin
    s1_d         = '0;
    s1_d.op      = to_round_i;
    s1_d.illegal = round_mode_i > 3'b100;
    s1_d.rm      = s1_d.illegal ? 3'b000 : round_mode_i;
    s1_d.inexact = |grs_i;
    s1_d.uf      = underflow_i;
    s1_d.dz      = zero_divide_i;
    unique case (s1_d.rm)
      3'b000:  s1_d.inc = grs_i[2] & (grs_i[1] | grs_i[0] | to_round_i[0]);
      3'b001:  s1_d.inc = 1'b0;
      3'b010:  s1_d.inc = to_round_i[31] & s1_d.inexact;
      3'b011:  s1_d.inc = ~to_round_i[31] & s1_d.inexact;
      default: s1_d.inc = grs_i[2];
    endcase
    if (invalid_op_i)                 s1_d.cls = CLS_INV;
    else if (to_round_i[30:23] == 8'hFF) s1_d.cls = CLS_PASS;
    else if (overflow_i)              s1_d.cls = CLS_OVF;
    else                              s1_d.cls = CLS_NORMAL;
  end

  // Stage 2: apply the increment and form the final result/flags
  logic [30:0] sum;
  logic        sgn;
  logic [31:0] res_d;
  logic [4:0]  ff_d;

  assign sum = s1_q.op[30:0] + {30'd0, s1_q.inc};
  assign sgn = s1_q.op[31];

  always_comb begin
    res_d = '0;
    ff_d  = '0;
    if (s1_q.cls == CLS_INV) begin
      res_d = CANON_NAN;
      ff_d  = 5'b10000;
    end else if (s1_q.cls == CLS_PASS) begin
      res_d = s1_q.op;
      ff_d  = {1'b0, s1_q.dz, 3'b000};
    end else if (s1_q.cls == CLS_OVF || sum[30:23] == 8'hFF) begin
      // Directed modes saturate to the largest finite value when rounding toward zero
      unique case (s1_q.rm)
        3'b001:  res_d = {sgn, MAX_MAG};
        3'b010:  res_d = {sgn, sgn ? INF_MAG : MAX_MAG};
        3'b011:  res_d = {sgn, sgn ? MAX_MAG : INF_MAG};
        default: res_d = {sgn, INF_MAG};
      endcase
      ff_d = 5'b00101;
    end else begin
      res_d = {sgn, sum};
      ff_d  = {3'b000, s1_q.inexact & (s1_q.uf | sum[30:23] == 8'h00), s1_q.inexact};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      s1_q         <= '0;
      result_o     <= '0;
      fflags_o     <= '0;
      illegal_rm_o <= 1'b0;
    end else if (flush_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (adv1) s1_v <= valid_i;
      if (adv1 && valid_i) s1_q <= s1_d;
      if (adv2) s2_v <= s1_v;
      if (adv2 && s1_v) begin
        result_o     <= res_d;
        fflags_o     <= ff_d;
        illegal_rm_o <= s1_q.illegal;
      end
    end
  end

endmodule
